// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: widths, ALU op codes, operand select encodings
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic SRCB_REG = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

endpackage

// File: rtl/forward_mux.sv
// rtl/forward_mux.sv - one operand's bypass select: MEM over WB over register file
module forward_mux #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic [RA_W-1:0] rdM,
  input  logic            regWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [RA_W-1:0] rdW,
  input  logic            regWriteW,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] value
);

  logic hit_m;
  logic hit_w;

  // x0 is hardwired zero, so a write to it must never be bypassed
  assign hit_m = regWriteM && (rdM != '0) && (rdM == rs);
  assign hit_w = regWriteW && (rdW != '0) && (rdW == rs);

  // younger MEM result shadows the older WB result
  always_comb begin
    value = rf_data;
    if (hit_m)      value = ALUResultM;
    else if (hit_w) value = resultW;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - D/E pipeline register with operand bypass and load-use detect
module ex_operand_stage #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validD,
  input  logic            stallE,
  input  logic            flushE,
  input  logic [RA_W-1:0] rs1D,
  input  logic [RA_W-1:0] rs2D,
  input  logic [RA_W-1:0] rdD,
  input  logic [XLEN-1:0] rd1D,
  input  logic [XLEN-1:0] rd2D,
  input  logic [XLEN-1:0] immD,
  input  logic [XLEN-1:0] pcD,
  input  logic [1:0]      srcASelD,
  input  logic            srcBSelD,
  input  logic [3:0]      ALUControlD,
  input  logic            regWriteD,
  input  logic            memReadD,
  input  logic [RA_W-1:0] rdM,
  input  logic            regWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [RA_W-1:0] rdW,
  input  logic            regWriteW,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [3:0]      ALUControl,
  output logic [XLEN-1:0] writeDataE,
  output logic [XLEN-1:0] pcE,
  output logic [RA_W-1:0] rdE,
  output logic            validE,
  output logic            regWriteE,
  output logic            memReadE,
  output logic            loadUseStall
);

  import core_pkg::*;

  logic            valid_q;
  logic [RA_W-1:0] rs1_q;
  logic [RA_W-1:0] rs2_q;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic [1:0]      srca_sel_q;
  logic            srcb_sel_q;
  logic [3:0]      alu_ctl_q;
  logic            reg_write_q;
  logic            mem_read_q;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // E register: flush (or an invalid decode slot) loads an all-zero bubble, stall holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      srca_sel_q  <= SRCA_REG;
      srcb_sel_q  <= SRCB_REG;
      alu_ctl_q   <= ALU_ADD;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (flushE || (!stallE && !validD)) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      srca_sel_q  <= SRCA_REG;
      srcb_sel_q  <= SRCB_REG;
      alu_ctl_q   <= ALU_ADD;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (!stallE) begin
      valid_q     <= 1'b1;
      rs1_q       <= rs1D;
      rs2_q       <= rs2D;
      rd_q        <= rdD;
      rd1_q       <= rd1D;
      rd2_q       <= rd2D;
      imm_q       <= immD;
      pc_q        <= pcD;
      srca_sel_q  <= srcASelD;
      srcb_sel_q  <= srcBSelD;
      alu_ctl_q   <= ALUControlD;
      reg_write_q <= regWriteD;
      mem_read_q  <= memReadD;
    end
  end

  forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
    .rs         (rs1_q),
    .rf_data    (rd1_q),
    .rdM        (rdM),
    .regWriteM  (regWriteM),
    .ALUResultM (ALUResultM),
    .rdW        (rdW),
    .regWriteW  (regWriteW),
    .resultW    (resultW),
    .value      (fwd_a)
  );

  forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
    .rs         (rs2_q),
    .rf_data    (rd2_q),
    .rdM        (rdM),
    .regWriteM  (regWriteM),
    .ALUResultM (ALUResultM),
    .rdW        (rdW),
    .regWriteW  (regWriteW),
    .resultW    (resultW),
    .value      (fwd_b)
  );

  // operand A source; the reserved encoding falls back to zero like SRCA_ZERO
  always_comb begin
    srcA = '0;
    case (srca_sel_q)
      SRCA_REG: srcA = fwd_a;
      SRCA_PC:  srcA = pc_q;
      default:  srcA = '0;
    endcase
  end

  // operand B source; stores always take the bypassed rs2 regardless of srcB
  always_comb begin
    srcB = (srcb_sel_q == SRCB_IMM) ? imm_q : fwd_b;
  end

  assign writeDataE = fwd_b;
  assign ALUControl = alu_ctl_q;
  assign pcE        = pc_q;
  assign rdE        = rd_q;
  assign validE     = valid_q;
  assign regWriteE  = valid_q & reg_write_q;
  assign memReadE   = valid_q & mem_read_q;

  // a load in E cannot bypass its data to a dependent instruction still in D
  assign loadUseStall = validE && memReadE && (rdE != '0) && validD &&
                        ((rdE == rs1D) || (rdE == rs2D));

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        validD, stallE, flushE;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [31:0] rd1D, rd2D, immD, pcD;
  logic [1:0]  srcASelD;
  logic        srcBSelD;
  logic [3:0]  ALUControlD;
  logic        regWriteD, memReadD;
  logic [4:0]  rdM, rdW;
  logic        regWriteM, regWriteW;
  logic [31:0] ALUResultM, resultW;
  logic [31:0] srcA, srcB, writeDataE, pcE;
  logic [3:0]  ALUControl;
  logic [4:0]  rdE;
  logic        validE, regWriteE, memReadE, loadUseStall;

  int n_assert = 0;
  int n_fail   = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .validD(validD), .stallE(stallE), .flushE(flushE),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .rd1D(rd1D), .rd2D(rd2D),
    .immD(immD), .pcD(pcD), .srcASelD(srcASelD), .srcBSelD(srcBSelD),
    .ALUControlD(ALUControlD), .regWriteD(regWriteD), .memReadD(memReadD),
    .rdM(rdM), .regWriteM(regWriteM), .ALUResultM(ALUResultM),
    .rdW(rdW), .regWriteW(regWriteW), .resultW(resultW),
    .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .writeDataE(writeDataE),
    .pcE(pcE), .rdE(rdE), .validE(validE), .regWriteE(regWriteE),
    .memReadE(memReadE), .loadUseStall(loadUseStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] asel,
                       input logic bsel, input logic [3:0] op, input logic rw, input logic mr);
    validD = v; rs1D = r1; rs2D = r2; rdD = rd; rd1D = d1; rd2D = d2;
    immD = imm; pcD = pc; srcASelD = asel; srcBSelD = bsel; ALUControlD = op;
    regWriteD = rw; memReadD = mr;
  endtask

  initial begin
    reset = 1'b1; stallE = 1'b0; flushE = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0);
    rdM = 5'd0; regWriteM = 1'b0; ALUResultM = 32'h0;
    rdW = 5'd0; regWriteW = 1'b0; resultW = 32'h0;
    #12;
    reset = 1'b0;

    // nonzero contents in E, then asynchronous reset between edges
    set_d(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 32'h40, 2'b00, 1'b0, 4'h1, 1'b1, 1'b1);
    step();
    chk("pre_reset_srcA", srcA, 32'h11);
    chk("pre_reset_alu", {28'h0, ALUControl}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_srcA", srcA, 32'h0);
    chk("rst_srcB", srcB, 32'h0);
    chk("rst_alu", {28'h0, ALUControl}, 32'h0);
    chk("rst_wdata", writeDataE, 32'h0);
    chk("rst_pcE", pcE, 32'h0);
    chk("rst_rdE", {27'h0, rdE}, 32'h0);
    chk("rst_validE", {31'h0, validE}, 32'h0);
    chk("rst_regWriteE", {31'h0, regWriteE}, 32'h0);
    chk("rst_memReadE", {31'h0, memReadE}, 32'h0);
    chk("rst_luStall", {31'h0, loadUseStall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // first instruction after reset
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h0, 32'h0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    chk("first_srcA", srcA, 32'd5);
    chk("first_srcB", srcB, 32'd7);
    chk("first_validE", {31'h0, validE}, 32'h1);

    // MEM vs WB priority on rs1
    set_d(1'b1, 5'd3, 5'd6, 5'd8, 32'h33, 32'h66, 32'h0, 32'h0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    regWriteM = 1'b1; rdM = 5'd3; ALUResultM = 32'hAA;
    regWriteW = 1'b1; rdW = 5'd3; resultW = 32'hBB;
    #1;
    chk("fwd_mem_prio", srcA, 32'hAA);
    chk("fwd_nohit_B", srcB, 32'h66);
    regWriteM = 1'b0;
    #1;
    chk("fwd_wb", srcA, 32'hBB);
    regWriteW = 1'b0; regWriteM = 1'b1; rdM = 5'd6; ALUResultM = 32'h1234;
    #1;
    chk("fwd_mem_B", srcB, 32'h1234);
    chk("fwd_mem_wdata", writeDataE, 32'h1234);
    chk("fwd_A_regfile", srcA, 32'h33);

    // rs1 == rs2 both take the same forwarded value
    set_d(1'b1, 5'd9, 5'd9, 5'd1, 32'h1, 32'h2, 32'h0, 32'h0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0);
    rdM = 5'd9; ALUResultM = 32'hCAFE;
    step();
    chk("same_rs_A", srcA, 32'hCAFE);
    chk("same_rs_B", srcB, 32'hCAFE);

    // x0 is never forwarded
    set_d(1'b1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0);
    regWriteM = 1'b1; rdM = 5'd0; ALUResultM = 32'hFF;
    regWriteW = 1'b1; rdW = 5'd0; resultW = 32'hFF;
    step();
    chk("x0_srcB", srcB, 32'h0);
    chk("x0_wdata", writeDataE, 32'h0);
    chk("x0_srcA", srcA, 32'h0);
    regWriteM = 1'b0; regWriteW = 1'b0;

    // load-use detection
    set_d(1'b1, 5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1, 4'h0, 1'b1, 1'b1);
    step();
    chk("load_memReadE", {31'h0, memReadE}, 32'h1);
    validD = 1'b1; rs1D = 5'd4; rs2D = 5'd9;
    #1;
    chk("lu_rs1", {31'h0, loadUseStall}, 32'h1);
    rs1D = 5'd9; rs2D = 5'd4;
    #1;
    chk("lu_rs2", {31'h0, loadUseStall}, 32'h1);
    validD = 1'b0;
    #1;
    chk("lu_invalidD", {31'h0, loadUseStall}, 32'h0);
    set_d(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1, 4'h0, 1'b1, 1'b1);
    step();
    rs1D = 5'd0; rs2D = 5'd0;
    #1;
    chk("lu_rd0", {31'h0, loadUseStall}, 32'h0);

    // stall holds E for three cycles while D changes
    set_d(1'b1, 5'd1, 5'd2, 5'd7, 32'h55, 32'h77, 32'h0, 32'h200, 2'b00, 1'b0, 4'h4, 1'b1, 1'b0);
    step();
    stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(1'b1, 5'd10 + 5'(i), 5'd11, 5'd12, 32'h1000 + i, 32'h2000 + i, 32'h1, 32'h300 + i,
            2'b01, 1'b1, 4'h9, 1'b0, 1'b1);
      step();
      chk("stall_srcA", srcA, 32'h55);
      chk("stall_srcB", srcB, 32'h77);
      chk("stall_pcE", pcE, 32'h200);
      chk("stall_alu", {28'h0, ALUControl}, 32'h4);
      chk("stall_rdE", {27'h0, rdE}, 32'd7);
    end
    flushE = 1'b1;
    step();
    chk("flush_validE", {31'h0, validE}, 32'h0);
    chk("flush_alu", {28'h0, ALUControl}, 32'h0);
    chk("flush_regWriteE", {31'h0, regWriteE}, 32'h0);
    chk("flush_memReadE", {31'h0, memReadE}, 32'h0);
    stallE = 1'b0; flushE = 1'b0;

    // PC / immediate operands with forwarded store data
    set_d(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h99, 32'h10, 32'h100, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0);
    regWriteM = 1'b1; rdM = 5'd2; ALUResultM = 32'hCC;
    step();
    chk("pc_srcA", srcA, 32'h100);
    chk("imm_srcB", srcB, 32'h10);
    chk("imm_wdata", writeDataE, 32'hCC);
    regWriteM = 1'b0;

    // reserved and zero select for A
    set_d(1'b1, 5'd1, 5'd2, 5'd3, 32'h123, 32'h0, 32'h0, 32'h44, 2'b11, 1'b0, 4'h2, 1'b1, 1'b0);
    step();
    chk("srcA_sel11", srcA, 32'h0);
    srcASelD = 2'b10;
    step();
    chk("srcA_sel10", srcA, 32'h0);

    // invalid decode loads a bubble
    set_d(1'b0, 5'd1, 5'd2, 5'd3, 32'h123, 32'h0, 32'h0, 32'h44, 2'b00, 1'b0, 4'h3, 1'b1, 1'b1);
    step();
    chk("bubble_validE", {31'h0, validE}, 32'h0);
    chk("bubble_regWriteE", {31'h0, regWriteE}, 32'h0);
    chk("bubble_alu", {28'h0, ALUControl}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
